decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Parametrised decode/issue stage for the pipelined MIPS core: it holds the register file, resolves operands with multi-source forwarding (EX, MEM, WB), detects load-use hazards, and owns the ID/EX pipeline register with a valid/ready handshake. It sits between the fetch stage and the execute stage. It adds flush support and a stall counter, and generalises data width and register count.

## Interface

Parameters:
- DATA_WIDTH, 32, register and operand width.
- REG_COUNT, 32, number of architectural registers; register 0 reads as zero. Address width RA = $clog2(REG_COUNT).
- CTRL_WIDTH, 16, opaque control bundle passed through unchanged.

Ports:
- clock  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode beat present.
- in_ready  out  1  stage accepts the beat this cycle.
- in_instruction  in  32  instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]; addresses truncated to RA bits.
- in_pc  in  32  instruction address.
- in_ctrl  in  CTRL_WIDTH  pass-through control bundle from the control unit.
- in_uses_rs, in_uses_rt  in  1 each  operand actually read.
- in_writes_reg, in_is_load, in_dest_rt_else_rd, in_sign_extend  in  1 each  decoded control bits.
- flush  in  1  squash the ID beat and the ID/EX register (taken branch or jump).
- ex_valid, ex_writes_reg, ex_is_load  in  1 each  state of the instruction in EX.
- ex_dest_addr  in  RA; ex_result  in  DATA_WIDTH  EX destination and ALU result.
- mem_writes_reg  in  1; mem_dest_addr  in  RA; mem_data  in  DATA_WIDTH  MEM-stage result.
- wb_write  in  1; wb_addr  in  RA; wb_data  in  DATA_WIDTH  register file write port.
- out_valid  out  1; out_ready  in  1  ID/EX handshake.
- out_pc  out  32; out_ctrl  out  CTRL_WIDTH; out_operand_a, out_operand_b, out_immediate  out  DATA_WIDTH; out_dest_addr  out  RA; out_writes_reg, out_is_load  out  1 each.
- stall_count  out  16  saturating count of load-use stall cycles.

## Operation

- Immediate: the 16-bit field is sign- or zero-extended to DATA_WIDTH according to in_sign_extend.
- Destination: rt if in_dest_rt_else_rd, otherwise rd. If the destination is 0, out_writes_reg is forced to 0.
- Operand priority per source (rs/rt), highest first:
  - 1. Address 0 gives 0.
  - 2. EX match (ex_valid & ex_writes_reg & !ex_is_load) gives ex_result.
  - 3. MEM match (mem_writes_reg) gives mem_data.
  - 4. WB match (wb_write) gives wb_data (write-through bypass).
  - 5. Otherwise the register file array.
- Load-use hazard: in_valid & ex_valid & ex_is_load & ex_dest_addr≠0 & ((in_uses_rs & rs==ex_dest_addr) | (in_uses_rt & rt==ex_dest_addr)).
- in_ready = (!out_valid | out_ready) & !hazard.
- ID/EX register update:
  - Load when in_valid & in_ready & !flush.
  - Insert a bubble (out_valid←0) when (!out_valid | out_ready) and (hazard | !in_valid).
  - Hold all fields when out_valid & !out_ready.
- flush: out_valid←0 on the next edge regardless of out_ready. Any beat accepted in the same cycle is discarded. Flush has priority over stall and hold.
- stall_count increments once per cycle with a hazard, and saturates at 0xFFFF.
- Register file: one write port, two asynchronous read ports; writes to address 0 are ignored.

## Timing

- Reset (synchronous): out_valid=0, stall_count=0, all out_* data fields 0, and all registers cleared to 0. in_ready follows its equation (1 after reset when there is no hazard).
- Latency: a beat accepted at edge t is presented at out_* after edge t with out_valid=1, i.e. 1 cycle.
- Forwarding and hazard logic are combinational in the accept cycle. A register-file write at edge t is visible to reads after t, and is bypassed during cycle t.
- A load-use stall lasts exactly as long as the condition holds, typically 1 cycle.
- Reset mid-stall or mid-hold discards the pending beat.

## Structure

- Shared package `pipeline_pkg`: RA derivation, field bit positions (RS_LSB, RT_LSB, RD_LSB), and the forwarding-select enum (FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF).
- One sub-module `register_file_bypass` (parametrised DATA_WIDTH/REG_COUNT, synchronous reset, internal WB bypass). The hazard, forwarding and ID/EX logic stay in the top module.

## Test plan

- Reset, then write r5=0x1234 through WB; next decode rs=5 → out_operand_a=0x1234, out_valid=1 one cycle after accept.
- EX holds non-load r3=0xAAAA and MEM holds r3=0xBBBB; decode rt=3 → out_operand_b=0xAAAA. Remove the EX match → 0xBBBB.
- EX load to r7, decode uses rs=7 → in_ready=0, bubble (out_valid=0) for 1 cycle, stall_count=1; the beat is accepted the next cycle with the MEM-forwarded value.
- out_ready=0 with out_valid=1 for 3 cycles → in_ready=0 and out_* stable; release → the next beat is accepted.
- flush asserted together with an accepted beat and out_ready=0 → out_valid=0 next cycle and the beat is lost.
- imm=0x8001: in_sign_extend=1 → 0xFFFF8001; =0 → 0x00008001. Destination rd=0 with in_writes_reg=1 → out_writes_reg=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode/issue pipeline slice.
//   - instruction field positions (rs, rt, rd, immediate)
//   - register-address width derivation from the register count
//   - operand forwarding source select
package pipeline_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int RS_LSB      = 21;
    localparam int RT_LSB      = 16;
    localparam int RD_LSB      = 11;
    localparam int IMM_WIDTH   = 16;
    localparam int STALL_WIDTH = 16;

    // A single-register file still needs a one-bit address.
    function automatic int ra_width(input int reg_count);
        return (reg_count > 1) ? $clog2(reg_count) : 1;
    endfunction

    // Operand source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

endpackage

// File: rtl/register_file_bypass.sv
// Architectural register file: one write port, two asynchronous read ports.
// Register 0 always reads as zero and ignores writes. A write presented in
// the current cycle is bypassed to the read ports so the reader sees it
// before the clock edge commits it.
//   clock, reset            : clock and synchronous active-high reset
//   i_wr_en/addr/data       : write port
//   i_rd_addr_a/o_rd_data_a : read port A
//   i_rd_addr_b/o_rd_data_b : read port B
module register_file_bypass
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_wr_en,
    input  logic [ra_width(REG_COUNT)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]            i_wr_data,
    input  logic [ra_width(REG_COUNT)-1:0]   i_rd_addr_a,
    output logic [DATA_WIDTH-1:0]            o_rd_data_a,
    input  logic [ra_width(REG_COUNT)-1:0]   i_rd_addr_b,
    output logic [DATA_WIDTH-1:0]            o_rd_data_b
);

    localparam int RA = ra_width(REG_COUNT);

    logic [DATA_WIDTH-1:0] r_mem [REG_COUNT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [RA-1:0] addr,
                                                        input logic [DATA_WIDTH-1:0] stored);
        if (addr == '0) begin
            return '0;
        end else if (i_wr_en && (i_wr_addr == addr)) begin
            return i_wr_data;
        end
        return stored;
    endfunction

    assign o_rd_data_a = read_port(i_rd_addr_a, r_mem[i_rd_addr_a]);
    assign o_rd_data_b = read_port(i_rd_addr_b, r_mem[i_rd_addr_b]);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage of the pipelined MIPS core.
// Reads operands from the register file with EX/MEM/WB forwarding, stalls on
// load-use hazards, and drives the ID/EX pipeline register through a
// valid/ready handshake. flush squashes both the beat in ID and the ID/EX
// register. stall_count saturates at all-ones.
//   clock, reset                    : clock, synchronous active-high reset
//   in_* (valid/ready/instruction..): decode beat from fetch + control unit
//   flush                           : taken branch / jump squash
//   ex_*, mem_*                     : forwarding / hazard sources
//   wb_*                            : register-file write port
//   out_* (valid/ready/fields)      : ID/EX register towards execute
//   stall_count                     : load-use stall cycles
module decode_issue_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,

    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instruction,
    input  logic [31:0]                    in_pc,
    input  logic [CTRL_WIDTH-1:0]          in_ctrl,
    input  logic                           in_uses_rs,
    input  logic                           in_uses_rt,
    input  logic                           in_writes_reg,
    input  logic                           in_is_load,
    input  logic                           in_dest_rt_else_rd,
    input  logic                           in_sign_extend,

    input  logic                           flush,

    input  logic                           ex_valid,
    input  logic                           ex_writes_reg,
    input  logic                           ex_is_load,
    input  logic [ra_width(REG_COUNT)-1:0] ex_dest_addr,
    input  logic [DATA_WIDTH-1:0]          ex_result,

    input  logic                           mem_writes_reg,
    input  logic [ra_width(REG_COUNT)-1:0] mem_dest_addr,
    input  logic [DATA_WIDTH-1:0]          mem_data,

    input  logic                           wb_write,
    input  logic [ra_width(REG_COUNT)-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,

    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic [DATA_WIDTH-1:0]          out_operand_a,
    output logic [DATA_WIDTH-1:0]          out_operand_b,
    output logic [DATA_WIDTH-1:0]          out_immediate,
    output logic [ra_width(REG_COUNT)-1:0] out_dest_addr,
    output logic                           out_writes_reg,
    output logic                           out_is_load,

    output logic [15:0]                    stall_count
);

    localparam int RA = ra_width(REG_COUNT);

    logic [RA-1:0]         w_rs;
    logic [RA-1:0]         w_rt;
    logic [RA-1:0]         w_rd;
    logic [RA-1:0]         w_dest;
    logic [15:0]           w_imm16;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [DATA_WIDTH-1:0] w_rf_a;
    logic [DATA_WIDTH-1:0] w_rf_b;
    logic [DATA_WIDTH-1:0] w_operand_a;
    logic [DATA_WIDTH-1:0] w_operand_b;
    fwd_sel_e              w_sel_a;
    fwd_sel_e              w_sel_b;
    logic                  w_ex_fwd_ok;
    logic                  w_hazard;
    logic                  w_slot_free;
    logic                  w_accept;
    logic                  w_unused_bits;

    logic                  r_out_valid;
    logic [31:0]           r_out_pc;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    logic [DATA_WIDTH-1:0] r_out_imm;
    logic [RA-1:0]         r_out_dest;
    logic                  r_out_writes_reg;
    logic                  r_out_is_load;
    logic [15:0]           r_stall_count;

    assign w_rs    = in_instruction[RS_LSB +: RA];
    assign w_rt    = in_instruction[RT_LSB +: RA];
    assign w_rd    = in_instruction[RD_LSB +: RA];
    assign w_imm16 = in_instruction[IMM_WIDTH-1:0];

    // Opcode bits are decoded upstream; only the operand fields are used here.
    assign w_unused_bits = &{1'b0, in_instruction[31:26]};

    assign w_imm_ext = in_sign_extend
                     ? {{(DATA_WIDTH-IMM_WIDTH){w_imm16[15]}}, w_imm16}
                     : {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, w_imm16};

    assign w_dest = in_dest_rt_else_rd ? w_rt : w_rd;

    register_file_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_register_file_bypass (
        .clock       (clock),
        .reset       (reset),
        .i_wr_en     (wb_write),
        .i_wr_addr   (wb_addr),
        .i_wr_data   (wb_data),
        .i_rd_addr_a (w_rs),
        .o_rd_data_a (w_rf_a),
        .i_rd_addr_b (w_rt),
        .o_rd_data_b (w_rf_b)
    );

    // A load in EX has no data yet; it is handled by the hazard stall instead.
    assign w_ex_fwd_ok = ex_valid & ex_writes_reg & ~ex_is_load;

    function automatic fwd_sel_e fwd_select(input logic [RA-1:0] addr);
        if (addr == '0) begin
            return FWD_ZERO;
        end else if (w_ex_fwd_ok && (ex_dest_addr == addr)) begin
            return FWD_EX;
        end else if (mem_writes_reg && (mem_dest_addr == addr)) begin
            return FWD_MEM;
        end else if (wb_write && (wb_addr == addr)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fwd_mux(input fwd_sel_e sel,
                                                      input logic [DATA_WIDTH-1:0] rf_data);
        case (sel)
            FWD_ZERO: return '0;
            FWD_EX:   return ex_result;
            FWD_MEM:  return mem_data;
            FWD_WB:   return wb_data;
            default:  return rf_data;
        endcase
    endfunction

    assign w_sel_a     = fwd_select(w_rs);
    assign w_sel_b     = fwd_select(w_rt);
    assign w_operand_a = fwd_mux(w_sel_a, w_rf_a);
    assign w_operand_b = fwd_mux(w_sel_b, w_rf_b);

    assign w_hazard = in_valid & ex_valid & ex_is_load & (ex_dest_addr != '0)
                    & ((in_uses_rs & (w_rs == ex_dest_addr))
                     | (in_uses_rt & (w_rt == ex_dest_addr)));

    assign w_slot_free = ~r_out_valid | out_ready;
    assign in_ready    = w_slot_free & ~w_hazard;
    assign w_accept    = in_valid & in_ready;

    // Fields are left untouched on a bubble or flush; only valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_pc         <= '0;
            r_out_ctrl       <= '0;
            r_out_a          <= '0;
            r_out_b          <= '0;
            r_out_imm        <= '0;
            r_out_dest       <= '0;
            r_out_writes_reg <= 1'b0;
            r_out_is_load    <= 1'b0;
        end else if (flush) begin
            r_out_valid      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_pc         <= in_pc;
            r_out_ctrl       <= in_ctrl;
            r_out_a          <= w_operand_a;
            r_out_b          <= w_operand_b;
            r_out_imm        <= w_imm_ext;
            r_out_dest       <= w_dest;
            r_out_writes_reg <= in_writes_reg & (w_dest != '0);
            r_out_is_load    <= in_is_load;
        end else if (w_slot_free) begin
            r_out_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_ctrl       = r_out_ctrl;
    assign out_operand_a  = r_out_a;
    assign out_operand_b  = r_out_b;
    assign out_immediate  = r_out_imm;
    assign out_dest_addr  = r_out_dest;
    assign out_writes_reg = r_out_writes_reg;
    assign out_is_load    = r_out_is_load;
    assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

    localparam int DW = 32;
    localparam int RC = 32;
    localparam int CW = 16;
    localparam int RA = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [31:0]   in_instruction, in_pc;
    logic [CW-1:0] in_ctrl;
    logic          in_uses_rs, in_uses_rt, in_writes_reg, in_is_load;
    logic          in_dest_rt_else_rd, in_sign_extend, flush;
    logic          ex_valid, ex_writes_reg, ex_is_load;
    logic [RA-1:0] ex_dest_addr;
    logic [DW-1:0] ex_result;
    logic          mem_writes_reg;
    logic [RA-1:0] mem_dest_addr;
    logic [DW-1:0] mem_data;
    logic          wb_write;
    logic [RA-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid, out_ready;
    logic [31:0]   out_pc;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_operand_a, out_operand_b, out_immediate;
    logic [RA-1:0] out_dest_addr;
    logic          out_writes_reg, out_is_load;
    logic [15:0]   stall_count;

    always #5 clock = ~clock;

    decode_issue_stage #(.DATA_WIDTH(DW), .REG_COUNT(RC), .CTRL_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
        .in_writes_reg(in_writes_reg), .in_is_load(in_is_load),
        .in_dest_rt_else_rd(in_dest_rt_else_rd), .in_sign_extend(in_sign_extend),
        .flush(flush),
        .ex_valid(ex_valid), .ex_writes_reg(ex_writes_reg), .ex_is_load(ex_is_load),
        .ex_dest_addr(ex_dest_addr), .ex_result(ex_result),
        .mem_writes_reg(mem_writes_reg), .mem_dest_addr(mem_dest_addr), .mem_data(mem_data),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
        .out_immediate(out_immediate), .out_dest_addr(out_dest_addr),
        .out_writes_reg(out_writes_reg), .out_is_load(out_is_load),
        .stall_count(stall_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_rf [RC];
    bit            m_valid;
    logic [31:0]   m_pc;
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [RA-1:0] m_dest;
    bit            m_wr, m_ld;
    int            m_stall;
    bit            m_after_reset;

    function automatic logic [DW-1:0] ref_operand(input logic [RA-1:0] a);
        if (a == 0) return '0;
        if (ex_valid && ex_writes_reg && !ex_is_load && ex_dest_addr == a) return ex_result;
        if (mem_writes_reg && mem_dest_addr == a) return mem_data;
        if (wb_write && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [15:0] low);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = rs;
        w[20:16] = rt;
        w[15:0]  = low;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RC; i++) m_rf[i] = '0;
        m_valid = 0; m_pc = '0; m_ctrl = '0; m_a = '0; m_b = '0; m_imm = '0;
        m_dest = '0; m_wr = 0; m_ld = 0; m_stall = 0; m_after_reset = 1;
    endtask

    // One clock: check in_ready in the current cycle, predict, clock, check outputs.
    task automatic step();
        logic [RA-1:0] rs, rt, rd, dst;
        bit            hz, rdy, n_valid, n_wr, n_ld;
        logic [31:0]   n_pc;
        logic [CW-1:0] n_ctrl;
        logic [DW-1:0] n_a, n_b, n_imm;
        logic [RA-1:0] n_dest;
        int            n_stall;
        bit            was_reset;
        #1;
        rs = in_instruction[25:21];
        rt = in_instruction[20:16];
        rd = in_instruction[15:11];
        hz = in_valid && ex_valid && ex_is_load && (ex_dest_addr != 0) &&
             ((in_uses_rs && rs == ex_dest_addr) || (in_uses_rt && rt == ex_dest_addr));
        rdy = (!m_valid || out_ready) && !hz;
        chk("in_ready", in_ready, rdy);
        n_valid = m_valid; n_pc = m_pc; n_ctrl = m_ctrl; n_a = m_a; n_b = m_b;
        n_imm = m_imm; n_dest = m_dest; n_wr = m_wr; n_ld = m_ld; n_stall = m_stall;
        was_reset = reset;
        if (!reset) begin
            if (flush) begin
                n_valid = 0;
            end else if (in_valid && rdy) begin
                dst     = in_dest_rt_else_rd ? rt : rd;
                n_valid = 1;
                n_pc    = in_pc;
                n_ctrl  = in_ctrl;
                n_a     = ref_operand(rs);
                n_b     = ref_operand(rt);
                n_imm   = in_sign_extend ? 32'($signed(in_instruction[15:0]))
                                         : 32'(in_instruction[15:0]);
                n_dest  = dst;
                n_wr    = in_writes_reg && (dst != 0);
                n_ld    = in_is_load;
            end else if (!m_valid || out_ready) begin
                n_valid = 0;
            end
            if (hz && n_stall < 65535) n_stall++;
        end
        @(posedge clock);
        if (was_reset) begin
            model_reset();
        end else begin
            if (wb_write && wb_addr != 0) m_rf[wb_addr] = wb_data;
            m_valid = n_valid; m_pc = n_pc; m_ctrl = n_ctrl; m_a = n_a; m_b = n_b;
            m_imm = n_imm; m_dest = n_dest; m_wr = n_wr; m_ld = n_ld; m_stall = n_stall;
            m_after_reset = 0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("stall_count", stall_count, m_stall);
        if (m_valid || m_after_reset) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_ctrl", out_ctrl, m_ctrl);
            chk("out_operand_a", out_operand_a, m_a);
            chk("out_operand_b", out_operand_b, m_b);
            chk("out_immediate", out_immediate, m_imm);
            chk("out_dest_addr", out_dest_addr, m_dest);
            chk("out_writes_reg", out_writes_reg, m_wr);
            chk("out_is_load", out_is_load, m_ld);
        end
    endtask

    task automatic clear_inputs();
        reset = 0; in_valid = 0; in_instruction = '0; in_pc = '0; in_ctrl = '0;
        in_uses_rs = 0; in_uses_rt = 0; in_writes_reg = 0; in_is_load = 0;
        in_dest_rt_else_rd = 0; in_sign_extend = 0; flush = 0;
        ex_valid = 0; ex_writes_reg = 0; ex_is_load = 0; ex_dest_addr = '0; ex_result = '0;
        mem_writes_reg = 0; mem_dest_addr = '0; mem_data = '0;
        wb_write = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    endtask

    task automatic randomize_inputs();
        logic [31:0] instr;
        reset = ($urandom_range(0, 99) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        instr = $urandom;
        instr[25:21] = 5'($urandom_range(0, 7));
        instr[20:16] = 5'($urandom_range(0, 7));
        instr[15:11] = 5'($urandom_range(0, 7));
        in_instruction = instr;
        in_pc = $urandom;
        in_ctrl = CW'($urandom);
        in_uses_rs = 1'($urandom); in_uses_rt = 1'($urandom);
        in_writes_reg = 1'($urandom); in_is_load = 1'($urandom);
        in_dest_rt_else_rd = 1'($urandom); in_sign_extend = 1'($urandom);
        flush = ($urandom_range(0, 15) == 0);
        ex_valid = 1'($urandom); ex_writes_reg = 1'($urandom);
        ex_is_load = ($urandom_range(0, 2) == 0);
        ex_dest_addr = 5'($urandom_range(0, 7)); ex_result = $urandom;
        mem_writes_reg = 1'($urandom); mem_dest_addr = 5'($urandom_range(0, 7));
        mem_data = $urandom;
        wb_write = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        step();                         // reset held: checks cleared outputs

        // WB write r5, then read it back through rs
        clear_inputs();
        wb_write = 1; wb_addr = 5; wb_data = 32'h1234;
        step();
        wb_write = 0;
        in_valid = 1; in_uses_rs = 1; in_pc = 32'h100;
        in_instruction = mk_instr(5, 0, 16'h0);
        step();
        chk("r5_operand_a", out_operand_a, 32'h1234);
        chk("r5_valid", out_valid, 1);

        // EX beats MEM, then MEM alone
        ex_valid = 1; ex_writes_reg = 1; ex_is_load = 0; ex_dest_addr = 3; ex_result = 32'hAAAA;
        mem_writes_reg = 1; mem_dest_addr = 3; mem_data = 32'hBBBB;
        in_uses_rs = 0; in_uses_rt = 1; in_instruction = mk_instr(0, 3, 16'h0);
        step();
        chk("ex_fwd_b", out_operand_b, 32'hAAAA);
        ex_writes_reg = 0;
        step();
        chk("mem_fwd_b", out_operand_b, 32'hBBBB);

        // Load-use stall on r7
        ex_valid = 1; ex_writes_reg = 1; ex_is_load = 1; ex_dest_addr = 7;
        mem_writes_reg = 0;
        in_uses_rs = 1; in_uses_rt = 0; in_instruction = mk_instr(7, 0, 16'h0);
        in_pc = 32'h200;
        step();
        chk("stall_bubble", out_valid, 0);
        chk("stall_one", stall_count, 1);
        ex_valid = 0; mem_writes_reg = 1; mem_dest_addr = 7; mem_data = 32'h7777;
        step();
        chk("post_stall_a", out_operand_a, 32'h7777);
        chk("post_stall_pc", out_pc, 32'h200);

        // Back-pressure hold for 3 cycles, then release
        mem_writes_reg = 0;
        out_ready = 0; in_pc = 32'h300;
        repeat (3) step();
        chk("hold_pc", out_pc, 32'h200);
        out_ready = 1;
        step();
        chk("release_pc", out_pc, 32'h300);

        // Flush with an accepted beat and out_ready low
        in_valid = 0;
        step();
        in_valid = 1; flush = 1; out_ready = 0; in_pc = 32'h400;
        step();
        chk("flush_drop", out_valid, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        step();

        // Immediate extension and rd=0 destination
        in_valid = 1; in_sign_extend = 1; in_instruction = mk_instr(1, 2, 16'h8001);
        step();
        chk("imm_sext", out_immediate, 32'hFFFF8001);
        in_sign_extend = 0;
        step();
        chk("imm_zext", out_immediate, 32'h00008001);
        in_writes_reg = 1; in_dest_rt_else_rd = 0; in_instruction = mk_instr(1, 2, 16'h0005);
        step();
        chk("rd0_no_write", out_writes_reg, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
